// File: rtl/tlb_engine_pkg.sv
// Shared definitions for the joint TLB: op encodings, size defaults and
// the EntryHi/EntryLo field layout.
package tlb_engine_pkg;

    localparam int TLBNUM_DEF = 16;
    localparam int IDXW_DEF   = 4;

    // EntryHi / EntryLo bit positions
    localparam int HI_VPN2_MSB = 31;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_ASID_MSB = 7;
    localparam int LO_PAGE_MSB = 25;
    localparam int LO_PAGE_LSB = 1;
    localparam int LO_G_BIT    = 0;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Field order mirrors EntryLo[25:1] so a page is a straight slice.
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } page_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational compare of one VPN2/ASID key against every TLB entry,
// with a lowest-index-wins priority encode.
module tlb_match
    import tlb_engine_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    parameter int IDXW   = IDXW_DEF
) (
    input  logic [TLBNUM-1:0]       e,
    input  logic [TLBNUM-1:0]       g,
    input  logic [TLBNUM-1:0][18:0] ent_vpn2,
    input  logic [TLBNUM-1:0][7:0]  ent_asid,
    input  logic [18:0]             vpn2,
    input  logic [7:0]              asid,
    output logic [TLBNUM-1:0]       hit,
    output logic [IDXW-1:0]         hit_index,
    output logic                    found
);

    genvar gi;
    generate
        for (gi = 0; gi < TLBNUM; gi++) begin : g_cmp
            assign hit[gi] = e[gi] && (ent_vpn2[gi] == vpn2) &&
                             (g[gi] || (ent_asid[gi] == asid));
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last assignment.
    always_comb begin
        hit_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) hit_index = IDXW'(i);
        end
    end

    assign found = |hit;

endmodule

// File: rtl/tlb_engine.sv
// 16-entry fully associative joint TLB: two registered lookup ports plus a
// serialised IDLE/EXEC/RESP engine for TLBP, TLBR, TLBWI and TLBWR.
module tlb_engine
    import tlb_engine_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    parameter int IDXW   = IDXW_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            s0_req,
    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd,
    input  logic [7:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,
    input  logic            s1_req,
    input  logic [18:0]     s1_vpn2,
    input  logic            s1_odd,
    input  logic [7:0]      s1_asid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_pfn,
    output logic [2:0]      s1_c,
    output logic            s1_d,
    output logic            s1_v,
    input  logic            op_valid,
    input  logic [1:0]      op_code,
    output logic            op_ready,
    output logic            op_done,
    input  logic [31:0]     cp0_entryhi,
    input  logic [31:0]     cp0_entrylo0,
    input  logic [31:0]     cp0_entrylo1,
    input  logic [31:0]     cp0_index,
    output logic            tlbp,
    output logic            tlbp_found,
    output logic [IDXW-1:0] index,
    output logic            tlbr,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [2:0]      r_c0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c1,
    output logic            r_d1,
    output logic            r_v1
);

    logic [TLBNUM-1:0]       e_reg, g_reg;
    logic [TLBNUM-1:0][18:0] vpn2_reg;
    logic [TLBNUM-1:0][7:0]  asid_reg;
    page_t [TLBNUM-1:0]      p0_reg, p1_reg;

    state_t          state_reg, state_next;
    op_t             code_reg;
    logic [18:0]     cap_vpn2_reg;
    logic [7:0]      cap_asid_reg;
    logic            cap_g_reg;
    page_t           cap_p0_reg, cap_p1_reg;
    logic [IDXW-1:0] cap_idx_reg, cap_rand_reg, rand_reg;

    logic            tlbp_found_reg;
    logic [IDXW-1:0] index_reg;
    logic [18:0]     r_vpn2_reg;
    logic [7:0]      r_asid_reg;
    logic            r_g_reg;
    page_t           r_p0_reg, r_p1_reg;

    logic [TLBNUM-1:0] probe_hit_unused;
    logic [IDXW-1:0]   probe_idx;
    logic              probe_found;
    logic              accept, wr_en;
    logic [IDXW-1:0]   wr_idx;
    logic              unused_cp0;

    assign unused_cp0 = ^{cp0_index[31:IDXW], cp0_entryhi[HI_VPN2_LSB-1:HI_ASID_MSB+1],
                          cp0_entrylo0[31:LO_PAGE_MSB+1], cp0_entrylo1[31:LO_PAGE_MSB+1]};

    assign accept = (state_reg == ST_IDLE) && op_valid;
    assign wr_en  = (state_reg == ST_EXEC) && ((code_reg == OP_TLBWI) || (code_reg == OP_TLBWR));
    assign wr_idx = (code_reg == OP_TLBWR) ? cap_rand_reg : cap_idx_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            rand_reg  <= IDXW'(TLBNUM - 1);
        end else begin
            state_reg <= state_next;
            rand_reg  <= (rand_reg == '0) ? IDXW'(TLBNUM - 1) : rand_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (op_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    // CP0 operands are frozen at accept so later CP0 writes cannot disturb the op.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_reg     <= OP_TLBP;
            cap_vpn2_reg <= '0;
            cap_asid_reg <= '0;
            cap_g_reg    <= 1'b0;
            cap_p0_reg   <= '0;
            cap_p1_reg   <= '0;
            cap_idx_reg  <= '0;
            cap_rand_reg <= '0;
        end else if (accept) begin
            code_reg     <= op_t'(op_code);
            cap_vpn2_reg <= cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
            cap_asid_reg <= cp0_entryhi[HI_ASID_MSB:0];
            cap_g_reg    <= cp0_entrylo0[LO_G_BIT] & cp0_entrylo1[LO_G_BIT];
            cap_p0_reg   <= page_t'(cp0_entrylo0[LO_PAGE_MSB:LO_PAGE_LSB]);
            cap_p1_reg   <= page_t'(cp0_entrylo1[LO_PAGE_MSB:LO_PAGE_LSB]);
            cap_idx_reg  <= cp0_index[IDXW-1:0];
            cap_rand_reg <= rand_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_reg    <= '0;
            g_reg    <= '0;
            vpn2_reg <= '0;
            asid_reg <= '0;
            p0_reg   <= '0;
            p1_reg   <= '0;
        end else if (wr_en) begin
            e_reg[wr_idx]    <= 1'b1;
            g_reg[wr_idx]    <= cap_g_reg;
            vpn2_reg[wr_idx] <= cap_vpn2_reg;
            asid_reg[wr_idx] <= cap_asid_reg;
            p0_reg[wr_idx]   <= cap_p0_reg;
            p1_reg[wr_idx]   <= cap_p1_reg;
        end
    end

    tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_probe (
        .e(e_reg), .g(g_reg), .ent_vpn2(vpn2_reg), .ent_asid(asid_reg),
        .vpn2(cap_vpn2_reg), .asid(cap_asid_reg),
        .hit(probe_hit_unused), .hit_index(probe_idx), .found(probe_found)
    );

    // A probe miss leaves index at its previous value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tlbp_found_reg <= 1'b0;
            index_reg      <= '0;
            r_vpn2_reg     <= '0;
            r_asid_reg     <= '0;
            r_g_reg        <= 1'b0;
            r_p0_reg       <= '0;
            r_p1_reg       <= '0;
        end else if (state_reg == ST_EXEC) begin
            if (code_reg == OP_TLBP) begin
                tlbp_found_reg <= probe_found;
                if (probe_found) index_reg <= probe_idx;
            end
            if (code_reg == OP_TLBR) begin
                r_vpn2_reg <= vpn2_reg[cap_idx_reg];
                r_asid_reg <= asid_reg[cap_idx_reg];
                r_g_reg    <= g_reg[cap_idx_reg];
                r_p0_reg   <= p0_reg[cap_idx_reg];
                r_p1_reg   <= p1_reg[cap_idx_reg];
            end
        end
    end

    assign op_ready   = (state_reg == ST_IDLE);
    assign op_done    = (state_reg == ST_RESP);
    assign tlbp       = (state_reg == ST_RESP) && (code_reg == OP_TLBP);
    assign tlbr       = (state_reg == ST_RESP) && (code_reg == OP_TLBR);
    assign tlbp_found = tlbp_found_reg;
    assign index      = index_reg;
    assign r_vpn2     = r_vpn2_reg;
    assign r_asid     = r_asid_reg;
    assign r_g        = r_g_reg;
    assign {r_pfn0, r_c0, r_d0, r_v0} = r_p0_reg;
    assign {r_pfn1, r_c1, r_d1, r_v1} = r_p1_reg;

    // Lookup ports: identical pipelines, packed into arrays for the generate.
    logic [1:0]            l_req, l_odd, l_found, l_found_q;
    logic [1:0][18:0]      l_vpn2;
    logic [1:0][7:0]       l_asid;
    logic [1:0][IDXW-1:0]  l_idx, l_idx_q;
    page_t [1:0]           l_page_q;
    logic [1:0][TLBNUM-1:0] l_hit_unused;

    assign l_req  = {s1_req, s0_req};
    assign l_odd  = {s1_odd, s0_odd};
    assign l_vpn2 = {s1_vpn2, s0_vpn2};
    assign l_asid = {s1_asid, s0_asid};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic            found_reg;
            logic [IDXW-1:0] idx_reg;
            page_t           page_reg;

            tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match (
                .e(e_reg), .g(g_reg), .ent_vpn2(vpn2_reg), .ent_asid(asid_reg),
                .vpn2(l_vpn2[gi]), .asid(l_asid[gi]),
                .hit(l_hit_unused[gi]), .hit_index(l_idx[gi]), .found(l_found[gi])
            );

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    found_reg <= 1'b0;
                    idx_reg   <= '0;
                    page_reg  <= '0;
                end else if (l_req[gi]) begin
                    found_reg <= l_found[gi];
                    idx_reg   <= l_idx[gi];
                    page_reg  <= l_odd[gi] ? p1_reg[l_idx[gi]] : p0_reg[l_idx[gi]];
                end
            end

            assign l_found_q[gi] = found_reg;
            assign l_idx_q[gi]   = idx_reg;
            assign l_page_q[gi]  = page_reg;
        end
    endgenerate

    assign s0_found = l_found_q[0];
    assign s0_index = l_idx_q[0];
    assign {s0_pfn, s0_c, s0_d, s0_v} = l_page_q[0];
    assign s1_found = l_found_q[1];
    assign s1_index = l_idx_q[1];
    assign {s1_pfn, s1_c, s1_d, s1_v} = l_page_q[1];

endmodule

// File: tb/tb_tlb_engine.sv
// Scoreboard bench for tlb_engine: lookup and engine expectations are queued
// when stimulus is driven and compared when the DUT responds.
module tb_tlb_engine;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s0_req = 0, s0_odd = 0, s1_req = 0, s1_odd = 0;
    logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0;
    logic [7:0]  s0_asid = '0, s1_asid = '0;
    logic        s0_found, s1_found, s0_d, s0_v, s1_d, s1_v;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        op_valid = 0;
    logic [1:0]  op_code = '0;
    logic        op_ready, op_done;
    logic [31:0] cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0, cp0_index = '0;
    logic        tlbp, tlbp_found, tlbr, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [3:0]  index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;

    int errors = 0;
    int checks = 0;
    int cyc;

    tlb_engine dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .tlbp(tlbp), .tlbp_found(tlbp_found), .index(index), .tlbr(tlbr),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the random register should read 15 - cyc mod 16.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int          port;
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } lk_exp_t;

    typedef struct {
        logic [1:0]  code;
        logic        pf;
        logic [3:0]  pidx;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [24:0] page0;
        logic [24:0] page1;
    } op_exp_t;

    lk_exp_t lk_q[$];
    op_exp_t op_q[$];

    task automatic lookup(input logic [1:0] ports, input logic [18:0] vpn2, input logic odd,
                          input logic [7:0] asid, input logic ef, input logic [3:0] ei,
                          input logic [19:0] ep, input logic [2:0] ec, input logic ed,
                          input logic ev);
        lk_exp_t x;
        logic af;
        logic [3:0] ai;
        logic [24:0] ap;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (ports[p]) begin
                x.port = p; x.found = ef; x.idx = ei; x.pfn = ep; x.c = ec; x.d = ed; x.v = ev;
                lk_q.push_back(x);
            end
        end
        if (ports[0]) begin s0_req = 1; s0_vpn2 = vpn2; s0_odd = odd; s0_asid = asid; end
        if (ports[1]) begin s1_req = 1; s1_vpn2 = vpn2; s1_odd = odd; s1_asid = asid; end
        @(posedge clk); #1;
        s0_req = 0; s1_req = 0;
        while (lk_q.size() > 0) begin
            x = lk_q.pop_front();
            af = (x.port == 0) ? s0_found : s1_found;
            ai = (x.port == 0) ? s0_index : s1_index;
            ap = (x.port == 0) ? {s0_pfn, s0_c, s0_d, s0_v} : {s1_pfn, s1_c, s1_d, s1_v};
            checks++;
            if (af !== x.found) begin
                errors++;
                $display("FAIL lookup_found port%0d vpn2=%h asid=%h: got %b want %b", x.port, vpn2, asid, af, x.found);
            end
            if (x.found) begin
                checks++;
                if (ai !== x.idx || ap !== {x.pfn, x.c, x.d, x.v}) begin
                    errors++;
                    $display("FAIL lookup_data port%0d vpn2=%h: got idx=%h page=%h want idx=%h page=%h",
                             x.port, vpn2, ai, ap, x.idx, {x.pfn, x.c, x.d, x.v});
                end
            end
            $display("lookup port%0d vpn2=%h odd=%b asid=%h -> found=%b idx=%0d pfn=%h", x.port, vpn2, odd, asid, af, ai, ap[24:5]);
        end
    endtask

    task automatic do_op(input op_exp_t x, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [3:0] idx, output int acc_cyc);
        int n;
        logic seen;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_ready_before_accept: got %b want 1", op_ready);
        end
        op_q.push_back(x);
        op_valid = 1; op_code = x.code;
        cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_index = {28'h0, idx};
        acc_cyc = cyc;
        @(posedge clk); #1;
        op_valid = 0;
        cp0_entryhi = ~hi; cp0_entrylo0 = ~lo0; cp0_entrylo1 = ~lo1; cp0_index = ~{28'h0, idx};
        n = 0; seen = 0;
        while (!seen && n < 6) begin
            @(posedge clk); #1;
            n++;
            if (op_done === 1'b1) seen = 1;
        end
        x = op_q.pop_front();
        checks++;
        if (!seen || n != 1) begin
            errors++;
            $display("FAIL op_done_latency code=%0d: got %0d edges (seen=%b) want 1", x.code, n, seen);
        end
        if (seen) begin
            checks++;
            if (tlbp !== (x.code == 2'd0) || tlbr !== (x.code == 2'd1)) begin
                errors++;
                $display("FAIL op_pulses code=%0d: got tlbp=%b tlbr=%b", x.code, tlbp, tlbr);
            end
            if (x.code == 2'd0) begin
                checks++;
                if (tlbp_found !== x.pf || index !== x.pidx) begin
                    errors++;
                    $display("FAIL tlbp_result: got found=%b index=%0d want found=%b index=%0d", tlbp_found, index, x.pf, x.pidx);
                end
            end
            if (x.code == 2'd1) begin
                checks++;
                if (r_vpn2 !== x.vpn2 || r_asid !== x.asid || r_g !== x.g) begin
                    errors++;
                    $display("FAIL tlbr_hi: got vpn2=%h asid=%h g=%b want vpn2=%h asid=%h g=%b", r_vpn2, r_asid, r_g, x.vpn2, x.asid, x.g);
                end
                checks++;
                if ({r_pfn0, r_c0, r_d0, r_v0} !== x.page0 || {r_pfn1, r_c1, r_d1, r_v1} !== x.page1) begin
                    errors++;
                    $display("FAIL tlbr_pages: got %h/%h want %h/%h", {r_pfn0, r_c0, r_d0, r_v0}, {r_pfn1, r_c1, r_d1, r_v1}, x.page0, x.page1);
                end
            end
        end
        $display("op code=%0d hi=%h idx=%0d -> done_after=%0d tlbp_found=%b index=%0d", x.code, hi, idx, n, tlbp_found, index);
        @(posedge clk); #1;
    endtask

    task automatic write_entry(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                               input logic [31:0] lo1, input logic [3:0] idx);
        op_exp_t x;
        int acc;
        x.code = code;
        do_op(x, hi, lo0, lo1, idx, acc);
    endtask

    task automatic test_reset();
        checks++;
        if (op_ready !== 1'b1 || op_done !== 1'b0 || tlbp !== 1'b0 || tlbr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b done=%b tlbp=%b tlbr=%b", op_ready, op_done, tlbp, tlbr);
        end
        checks++;
        if (s0_found !== 1'b0 || s1_found !== 1'b0 || tlbp_found !== 1'b0 || index !== 4'd0 ||
            r_vpn2 !== 19'd0 || r_pfn0 !== 20'd0 || s0_pfn !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got s0f=%b s1f=%b pf=%b idx=%h rvpn2=%h", s0_found, s1_found, tlbp_found, index, r_vpn2);
        end
        $display("reset ready=%b done=%b", op_ready, op_done);
        @(negedge clk); resetn = 1;
        lookup(2'b11, 19'h0, 1'b0, 8'h00, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_write_lookup();
        write_entry(2'd2, 32'h0040_2011, 32'h0000_1017, 32'h0000_2016, 4'd5);
        lookup(2'b01, 19'h00201, 1'b0, 8'h11, 1'b1, 4'd5, 20'h00040, 3'd2, 1'b1, 1'b1);
        lookup(2'b01, 19'h00201, 1'b1, 8'h11, 1'b1, 4'd5, 20'h00080, 3'd2, 1'b1, 1'b1);
        lookup(2'b10, 19'h00201, 1'b1, 8'h11, 1'b1, 4'd5, 20'h00080, 3'd2, 1'b1, 1'b1);
    endtask

    task automatic test_asid_global();
        lookup(2'b01, 19'h00201, 1'b0, 8'h22, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        write_entry(2'd2, 32'h0040_2011, 32'h0000_1017, 32'h0000_2017, 4'd5);
        lookup(2'b10, 19'h00201, 1'b1, 8'h22, 1'b1, 4'd5, 20'h00080, 3'd2, 1'b1, 1'b1);
        write_entry(2'd2, 32'h0040_2011, 32'h0000_1017, 32'h0000_2016, 4'd5);
        lookup(2'b01, 19'h00201, 1'b0, 8'h22, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_tlbp();
        op_exp_t x;
        int acc;
        x.code = 2'd0; x.pf = 1'b1; x.pidx = 4'd5;
        do_op(x, 32'h0040_2011, 32'h0, 32'h0, 4'd0, acc);
        x.pf = 1'b0; x.pidx = 4'd5;
        do_op(x, 32'h007F_E011, 32'h0, 32'h0, 4'd0, acc);
        write_entry(2'd2, 32'h0024_6044, 32'h0000_0003, 32'h0000_0001, 4'd7);
        write_entry(2'd2, 32'h0024_6044, 32'h0000_0003, 32'h0000_0001, 4'd3);
        x.pf = 1'b1; x.pidx = 4'd3;
        do_op(x, 32'h0024_6044, 32'h0, 32'h0, 4'd0, acc);
        lookup(2'b10, 19'h00123, 1'b0, 8'h99, 1'b1, 4'd3, 20'h0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_tlbr();
        op_exp_t x;
        int acc;
        x.code = 2'd1; x.vpn2 = 19'h00201; x.asid = 8'h11; x.g = 1'b0;
        x.page0 = {20'h00040, 3'd2, 1'b1, 1'b1};
        x.page1 = {20'h00080, 3'd2, 1'b1, 1'b1};
        do_op(x, 32'h0, 32'h0, 32'h0, 4'd5, acc);
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        lookup(2'b11, 19'h00201, 1'b0, 8'h11, 1'b1, 4'd5, 20'h00040, 3'd2, 1'b1, 1'b1);
        @(negedge clk);
        s0_vpn2 = 19'h7ffff; s1_vpn2 = 19'h7ffff;
        @(posedge clk); #1;
        checks++;
        if (s0_found !== 1'b1 || s0_index !== 4'd5 || s1_pfn !== 20'h00040) begin
            errors++;
            $display("FAIL lookup_hold: got s0f=%b s0idx=%0d s1pfn=%h", s0_found, s0_index, s1_pfn);
        end
        $display("hold s0_found=%b s0_index=%0d s1_pfn=%h", s0_found, s0_index, s1_pfn);
        @(negedge clk);
        op_valid = 1; op_code = 2'd0; cp0_entryhi = 32'h0040_2011;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (op_done === 1'b1) done_cnt++;
            if (k == 2) op_valid = 0;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_hold_done_count: got %0d want 1", done_cnt);
        end
        $display("busy hold op_done count=%0d", done_cnt);
    endtask

    task automatic test_reset_exec();
        int done_cnt;
        @(negedge clk);
        op_valid = 1; op_code = 2'd2; cp0_entryhi = 32'h000E_E000;
        cp0_entrylo0 = 32'h2; cp0_entrylo1 = 32'h2; cp0_index = 32'd9;
        @(posedge clk); #1;
        op_valid = 0;
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_busy: got op_ready=%b want 0", op_ready);
        end
        resetn = 0;
        #1;
        checks++;
        if (op_ready !== 1'b1 || op_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_exec: got ready=%b done=%b want 1/0", op_ready, op_done);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk); resetn = 1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (op_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_drop_done: got %0d op_done want 0", done_cnt);
        end
        $display("reset in exec op_done count=%0d", done_cnt);
        lookup(2'b01, 19'h00077, 1'b0, 8'h00, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_tlbwr();
        op_exp_t x;
        int acc;
        logic [3:0] slot;
        @(negedge clk); resetn = 0;
        @(posedge clk);
        @(negedge clk); resetn = 1;
        repeat (7) @(posedge clk);
        x.code = 2'd3;
        do_op(x, 32'h00AA_A001, 32'h0000_3002, 32'h0000_3002, 4'd0, acc);
        slot = 4'(15 - (acc % 16));
        $display("tlbwr accept cycle=%0d expected slot=%0d", acc, slot);
        lookup(2'b01, 19'h00555, 1'b0, 8'h01, 1'b1, slot, 20'h000C0, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_write_lookup();
        test_asid_global();
        test_tlbp();
        test_tlbr();
        test_back_to_back();
        test_reset_exec();
        test_tlbwr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
